dm_access_unit: RTL and testbench
=================================

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum cycles to wait for ram_ack before an access fault.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  MEM-stage access request, held high until cpu_ready.
REQ-005 cpu_we  input  1  1=store, 0=load.
REQ-006 cpu_addr  input  32  byte address (MEM-stage ALU result).
REQ-007 cpu_wdata  input  32  store data, right-aligned.
REQ-008 cpu_dmtype  input  3  access size/sign, DM_* encoding.
REQ-009 cpu_rdata  output  32  extended load data, valid while cpu_ready=1.
REQ-010 cpu_ready  output  1  one-cycle completion pulse (drives CPU MIO_ready).
REQ-011 cpu_fault  output  1  qualifies cpu_ready: the access failed.
REQ-012 cpu_cause  output  8  fault code, valid when cpu_fault=1.
REQ-013 ram_req  output  1  RAM request, registered.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_addr  output  30  word address, cpu_addr[31:2].
REQ-016 ram_be  output  4  byte enables, bit i = byte lane i.
REQ-017 ram_wdata  output  32  lane-replicated store data.
REQ-018 ram_rdata  input  32  RAM read word, valid with ram_ack.
REQ-019 ram_ack  input  1  RAM completion, any cycle at or after ram_req.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-021 IDLE, cpu_req=1, aligned: latch all request fields, assert ram_req/ram_we/ram_addr/ram_be/ram_wdata from the next cycle, enter ACCESS, clear the wait counter.
REQ-022 Alignment: word needs addr[1:0]=00; halfword needs addr[0]=0; byte is always aligned.
REQ-023 IDLE, cpu_req=1, misaligned: enter RESP with cpu_fault=1 and cause 4 (load) or 6 (store); ram_req SHALL stay 0.
REQ-024 ACCESS: RAM outputs SHALL hold stable until ram_ack; on ram_ack capture ram_rdata, deassert ram_req next cycle, enter RESP.
REQ-025 ACCESS: the counter SHALL increment each cycle without ack; at count==TIMEOUT, drop ram_req and enter RESP with cpu_fault=1 and cause 5 (load) or 7 (store).
REQ-026 ram_ack and count==TIMEOUT in the same cycle: the ack SHALL win and no fault is raised.
REQ-027 RESP: cpu_ready=1 for exactly one cycle, then IDLE; a new request SHALL NOT be accepted in RESP.
REQ-028 Minimum latency: request seen in cycle 0, ram_req in cycle 1, ack in cycle 1, cpu_ready in cycle 2.
REQ-029 Store ram_be: word 1111; halfword 0011<<(2*addr[1]); byte 0001<<addr[1:0].
REQ-030 ram_wdata: word passthrough; halfword {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-031 Load ram_be SHALL be 1111. The lane is selected by the latched addr[1:0].
REQ-032 Load extension: DM_HALFWORD and DM_BYTE sign-extend; DM_HALFWORD_UNSIGNED and DM_BYTE_UNSIGNED zero-extend.
REQ-033 Undefined cpu_dmtype SHALL be treated as a word access.
REQ-034 cpu_rdata SHALL be 0 when not in RESP, on faults, and on stores.
REQ-035 ram_ack outside ACCESS SHALL be ignored.

Reset
REQ-036 Reset SHALL force IDLE and clear the counter and all outputs to 0, including mid-ACCESS; an aborted RAM access is not retried.

Structure
REQ-037 The shared encode-definitions package SHALL hold the DM_WORD=000, DM_HALFWORD=001, DM_HALFWORD_UNSIGNED=010, DM_BYTE=011 and DM_BYTE_UNSIGNED=100 codes, the FSM state codes, and the cause constants 4/5/6/7.
REQ-038 One combinational sub-module, dm_lane_align, SHALL compute ram_be, ram_wdata and load extension; the FSM and counter stay in dm_access_unit.

Verification
REQ-039 Load word: addr 0x1000, ack after 3 cycles, rdata 0xDEADBEEF -> cpu_ready in cycle 5, cpu_rdata 0xDEADBEEF, ram_be 1111.
REQ-040 Load byte signed vs unsigned: addr 0x1003, rdata 0x80123456 -> DM_BYTE gives 0xFFFFFF80, DM_BYTE_UNSIGNED gives 0x00000080.
REQ-041 Store halfword: addr 0x2002, wdata 0x0000ABCD -> ram_be 1100, ram_wdata 0xABCDABCD, ram_we=1.
REQ-042 Misaligned word load at addr 0x1001 -> ram_req never 1, cpu_ready=1 in cycle 1 with cpu_fault=1 and cause 4.
REQ-043 Timeout: store with ram_ack tied to 0, TIMEOUT=15 -> ram_req drops after 15 wait cycles, cpu_fault=1, cause 7; ack coincident with count 15 -> no fault.
REQ-044 Reset asserted mid-ACCESS -> all outputs 0 immediately; the next request completes normally.

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access-size codes,
// FSM state codes, fault causes and the alignment rule.
package dm_access_unit_pkg;

  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  localparam logic [7:0] CAUSE_LOAD_MISALIGN  = 8'd4;
  localparam logic [7:0] CAUSE_LOAD_FAULT     = 8'd5;
  localparam logic [7:0] CAUSE_STORE_MISALIGN = 8'd6;
  localparam logic [7:0] CAUSE_STORE_FAULT    = 8'd7;

  // Unknown size codes fall through to the word rule.
  function automatic logic dm_is_aligned(input logic [2:0] dmtype, input logic [1:0] off);
    case (dmtype)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return ~off[0];
      DM_BYTE, DM_BYTE_UNSIGNED:         return 1'b1;
      default:                           return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, plus
// lane selection and sign/zero extension of load data.
module dm_lane_align
  import dm_access_unit_pkg::*;
(
  input  logic [2:0]  dmtype_i,
  input  logic [1:0]  byte_off_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half;
  logic [7:0]  bytev;

  always_comb begin
    half = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (byte_off_i)
      2'd0:    bytev = rdata_i[7:0];
      2'd1:    bytev = rdata_i[15:8];
      2'd2:    bytev = rdata_i[23:16];
      default: bytev = rdata_i[31:24];
    endcase
  end

  // Loads always fetch the full word; lane selection happens on the way back.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (dmtype_i)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
        if (we_i) be_o = 4'b0011 << {byte_off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (dmtype_i == DM_HALFWORD_UNSIGNED) ? {16'h0000, half}
                                                     : {{16{half[15]}}, half};
      end
      DM_BYTE, DM_BYTE_UNSIGNED: begin
        if (we_i) be_o = 4'b0001 << byte_off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (dmtype_i == DM_BYTE_UNSIGNED) ? {24'h000000, bytev}
                                                 : {{24{bytev[7]}}, bytev};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns a held MEM-stage request into one RAM
// transaction with alignment checking, ack timeout and a one-cycle response.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_fault,
  output logic [7:0]  cpu_cause,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam int CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  dm_state_e        state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ram_req_q, ram_req_d;
  logic             fault_q, fault_d;
  logic [7:0]       cause_q, cause_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [2:0]       dmtype_q, dmtype_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ram_req_q <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dmtype_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ram_req_q <= ram_req_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      dmtype_q  <= dmtype_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ram_req_d = ram_req_q;
    fault_d   = fault_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    we_d      = we_q;
    dmtype_d  = dmtype_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          we_d     = cpu_we;
          dmtype_d = cpu_dmtype;
          wdata_d  = cpu_wdata;
          rdata_d  = '0;
          count_d  = '0;
          if (dm_is_aligned(cpu_dmtype, cpu_addr[1:0])) begin
            ram_req_d = 1'b1;
            fault_d   = 1'b0;
            cause_d   = '0;
            state_d   = ST_ACCESS;
          end else begin
            fault_d = 1'b1;
            cause_d = cpu_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
            state_d = ST_RESP;
          end
        end
      end
      // An ack arriving on the timeout cycle still completes the access.
      ST_ACCESS: begin
        if (ram_ack) begin
          rdata_d   = ram_rdata;
          ram_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (count_q == TimeoutVal) begin
          ram_req_d = 1'b0;
          fault_d   = 1'b1;
          cause_d   = we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          state_d   = ST_RESP;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  dm_lane_align u_lane_align (
    .dmtype_i   (dmtype_q),
    .byte_off_i (addr_q[1:0]),
    .we_i       (we_q),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata_q),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  always_comb begin
    cpu_ready = (state_q == ST_RESP);
    cpu_fault = cpu_ready & fault_q;
    cpu_cause = cpu_fault ? cause_q : 8'h00;
    cpu_rdata = (cpu_ready & ~fault_q & ~we_q) ? lane_rdata : 32'h0;
    ram_req   = ram_req_q;
    ram_we    = ram_req_q & we_q;
    ram_addr  = ram_req_q ? addr_q[31:2] : 30'h0;
    ram_be    = ram_req_q ? lane_be : 4'h0;
    ram_wdata = ram_req_q ? lane_wdata : 32'h0;
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed, table-driven bench for dm_access_unit with a few hand-written
// sequences for reset during an access and stray acks.
module tb_dm_access_unit;
  import dm_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  cpu_dmtype = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_fault;
  logic [7:0]  cpu_cause;
  logic        ram_req;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;

  int assertions = 0;
  int failures = 0;

  dm_access_unit #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_dmtype (cpu_dmtype),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_fault  (cpu_fault),
    .cpu_cause  (cpu_cause),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  dmtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackCycle;
    logic [31:0] rdata;
    int          expReady;
    logic        expFault;
    logic [7:0]  expCause;
    logic [31:0] expRdata;
    int          expReqCycles;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs[NumVecs];

  task automatic checkOutput(input string name, input int idx,
                             input logic [127:0] act, input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return {18'h0, cpu_ready, cpu_fault, cpu_cause, cpu_rdata,
            ram_req, ram_we, ram_addr, ram_be, ram_wdata};
  endfunction

  // Runs one request starting on a negedge; cycle 0 is the cycle cpu_req rises.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          readyCycle = -1;
    int          reqCycles = 0;
    bit          sawReq = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wd = '0;
    logic [29:0] ad = '0;
    logic        wen = 1'b0;
    logic        flt = 1'b0;
    logic [7:0]  cs = '0;
    logic [31:0] rd = '0;
    cpu_req    = 1'b1;
    cpu_we     = v.we;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
    cpu_dmtype = v.dmtype;
    ram_rdata  = v.rdata;
    ram_ack    = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ram_req) begin
        if (!sawReq) begin
          be = ram_be; wd = ram_wdata; ad = ram_addr; wen = ram_we;
          sawReq = 1'b1;
        end
        reqCycles++;
      end
      if (cpu_ready) begin
        readyCycle = cyc;
        flt = cpu_fault; cs = cpu_cause; rd = cpu_rdata;
        break;
      end
      ram_ack = (cyc == v.ackCycle);
    end
    cpu_req = 1'b0;
    ram_ack = 1'b0;
    checkOutput("readyCycle", idx, 128'(readyCycle), 128'(v.expReady));
    checkOutput("fault", idx, 128'(flt), 128'(v.expFault));
    checkOutput("cause", idx, 128'(cs), 128'(v.expCause));
    checkOutput("rdata", idx, 128'(rd), 128'(v.expRdata));
    checkOutput("reqCycles", idx, 128'(reqCycles), 128'(v.expReqCycles));
    if (v.expReqCycles > 0) begin
      checkOutput("ramBe", idx, 128'(be), 128'(v.expBe));
      checkOutput("ramWe", idx, 128'(wen), 128'(v.we));
      checkOutput("ramAddr", idx, 128'(ad), 128'(v.addr >> 2));
      if (v.we) checkOutput("ramWdata", idx, 128'(wd), 128'(v.expWdata));
    end
    @(negedge clk);
    checkOutput("readyPulse", idx, 128'(cpu_ready), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            we    dmtype              addr          wdata         ack rdata         rdy flt cause rdata expected     req be    wdata expected
    vecs[0]  = '{1'b0, DM_WORD,             32'h0000_1000, 32'h0,         4, 32'hDEADBEEF,  5, 1'b0, 8'd0, 32'hDEADBEEF,  4, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, DM_BYTE,             32'h0000_1003, 32'h0,         1, 32'h80123456,  2, 1'b0, 8'd0, 32'hFFFFFF80,  1, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, DM_BYTE_UNSIGNED,    32'h0000_1003, 32'h0,         1, 32'h80123456,  2, 1'b0, 8'd0, 32'h00000080,  1, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, DM_HALFWORD,         32'h0000_2002, 32'h0000ABCD,  2, 32'hFFFFFFFF,  3, 1'b0, 8'd0, 32'h0,         2, 4'hC, 32'hABCDABCD};
    vecs[4]  = '{1'b0, DM_WORD,             32'h0000_1001, 32'h0,        99, 32'h12345678,  1, 1'b1, 8'd4, 32'h0,         0, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, DM_HALFWORD,         32'h0000_2003, 32'h00001234, 99, 32'h0,         1, 1'b1, 8'd6, 32'h0,         0, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, DM_HALFWORD,         32'h0000_3002, 32'h0,         1, 32'h80017FFF,  2, 1'b0, 8'd0, 32'hFFFF8001,  1, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, DM_HALFWORD_UNSIGNED,32'h0000_3000, 32'h0,         1, 32'h8001F00D,  2, 1'b0, 8'd0, 32'h0000F00D,  1, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, DM_BYTE,             32'h0000_4001, 32'h123456A5,  1, 32'h0,         2, 1'b0, 8'd0, 32'h0,         1, 4'h2, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, DM_WORD,             32'h0000_5000, 32'hCAFEF00D,  3, 32'h0,         4, 1'b0, 8'd0, 32'h0,         3, 4'hF, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 3'b111,              32'h0000_6000, 32'h0,         1, 32'h11223344,  2, 1'b0, 8'd0, 32'h11223344,  1, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 3'b101,              32'h0000_6002, 32'h0,        99, 32'h0,         1, 1'b1, 8'd4, 32'h0,         0, 4'h0, 32'h0};
    vecs[12] = '{1'b0, DM_BYTE,             32'h0000_1001, 32'h0,         1, 32'h00007F00,  2, 1'b0, 8'd0, 32'h0000007F,  1, 4'hF, 32'h0};
    vecs[13] = '{1'b1, DM_WORD,             32'h0000_7000, 32'h00000001, 99, 32'h0,        17, 1'b1, 8'd7, 32'h0,        16, 4'hF, 32'h00000001};
    vecs[14] = '{1'b0, DM_WORD,             32'h0000_7004, 32'h0,        99, 32'h0BADF00D, 17, 1'b1, 8'd5, 32'h0,        16, 4'hF, 32'h0};
    vecs[15] = '{1'b0, DM_WORD,             32'h0000_7004, 32'h0,        16, 32'h0BADF00D, 17, 1'b0, 8'd0, 32'h0BADF00D, 16, 4'hF, 32'h0};
    vecs[16] = '{1'b1, DM_HALFWORD_UNSIGNED,32'h0000_2000, 32'hFFFF1234,  1, 32'h0,         2, 1'b0, 8'd0, 32'h0,         1, 4'h3, 32'h12341234};
    vecs[17] = '{1'b1, DM_BYTE_UNSIGNED,    32'h0000_4003, 32'h0000007E,  1, 32'h0,         2, 1'b0, 8'd0, 32'h0,         1, 4'h8, 32'h7E7E7E7E};

    $display("[TB] reset and idle checks");
    @(negedge clk);
    checkOutput("resetOutputs", -1, allOutputs(), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleOutputs", -1, allOutputs(), 128'h0);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < NumVecs; i++) applyStimulus(vecs[i], i);

    $display("[TB] stray ack while idle");
    ram_rdata = 32'hFFFF_FFFF;
    ram_ack   = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    checkOutput("strayAckReady", -1, 128'(cpu_ready), 128'(0));
    @(negedge clk);
    checkOutput("strayAckOutputs", -1, allOutputs(), 128'h0);

    $display("[TB] reset in the middle of an access");
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 32'h0000_8000;
    cpu_wdata  = 32'h55AA55AA;
    cpu_dmtype = DM_WORD;
    repeat (3) @(negedge clk);
    checkOutput("midAccessReq", -1, 128'(ram_req), 128'(1));
    reset = 1'b1;
    #1;
    checkOutput("midAccessReset", -1, allOutputs(), 128'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("noRetry", -1, allOutputs(), 128'h0);
    applyStimulus(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
